// File: rtl/pc_fetch_unit.sv
// PC owner and instruction fetch front end for the multicycle core.
// Optional sequential prefetch buffer enabled by defining PC_FETCH_PREFETCH_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          AW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] npc_in,
  input  logic          npc_valid,
  output logic [AW-1:0] pc_out,
  output logic [AW-1:0] link_out,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   instr_out,
  output logic          instr_valid,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_ISSUE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_d;
  logic [31:0]   r_instr;
  logic [31:0]   w_instr_d;
  logic          r_ivalid;
  logic          w_ivalid_d;
  logic          w_req;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] w_link;

  assign w_link = r_pc + {{(AW-1){1'b0}}, 1'b1};

`ifdef PC_FETCH_PREFETCH_EN
  logic          r_pf_req;
  logic          w_pf_req_d;
  logic          r_pf_out;
  logic          w_pf_out_d;
  logic          r_pf_valid;
  logic          w_pf_valid_d;
  logic [31:0]   r_pf_data;
  logic [31:0]   w_pf_data_d;
  logic          r_drain;
  logic          w_drain_d;
  logic          w_seq;
  logic          w_pf_hit;
  logic          w_pf_busy;

  assign w_seq     = (npc_in == w_link);
  assign w_pf_hit  = r_pf_valid | (r_pf_out & imem_rvalid);
  // a response is still owed to us after this cycle
  assign w_pf_busy = (r_pf_out & ~imem_rvalid) | (r_pf_req & imem_gnt);
`endif

  always_comb begin
    w_next     = r_state;
    w_pc_d     = r_pc;
    w_instr_d  = r_instr;
    w_ivalid_d = r_ivalid;
    w_req      = 1'b0;
    w_addr     = r_pc;
`ifdef PC_FETCH_PREFETCH_EN
    w_pf_req_d   = r_pf_req;
    w_pf_out_d   = r_pf_out;
    w_pf_valid_d = r_pf_valid;
    w_pf_data_d  = r_pf_data;
    w_drain_d    = r_drain;
`endif
    unique case (r_state)
      S_BOOT: w_next = S_REQ;
      S_REQ: begin
        w_req = 1'b1;
        if (imem_gnt) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
`ifdef PC_FETCH_PREFETCH_EN
          if (r_drain) begin
            w_drain_d = 1'b0;
            w_next    = S_REQ;
          end else begin
            w_instr_d    = imem_rdata;
            w_ivalid_d   = 1'b1;
            w_next       = S_ISSUE;
            w_pf_req_d   = 1'b1;
            w_pf_valid_d = 1'b0;
          end
`else
          w_instr_d  = imem_rdata;
          w_ivalid_d = 1'b1;
          w_next     = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
`ifdef PC_FETCH_PREFETCH_EN
        w_req  = r_pf_req;
        w_addr = w_link;
        if (r_pf_req && imem_gnt) begin
          w_pf_req_d = 1'b0;
          w_pf_out_d = 1'b1;
        end
        if (r_pf_out && imem_rvalid) begin
          w_pf_out_d   = 1'b0;
          w_pf_valid_d = 1'b1;
          w_pf_data_d  = imem_rdata;
        end
        if (npc_valid) begin
          w_pc_d = npc_in;
          if (w_seq && w_pf_hit) begin
            w_instr_d    = r_pf_valid ? r_pf_data : imem_rdata;
            w_pf_req_d   = 1'b1;
            w_pf_out_d   = 1'b0;
            w_pf_valid_d = 1'b0;
          end else begin
            w_ivalid_d   = 1'b0;
            w_pf_req_d   = 1'b0;
            w_pf_out_d   = 1'b0;
            w_pf_valid_d = 1'b0;
            if (w_pf_busy) begin
              w_next    = S_WAIT;
              w_drain_d = ~w_seq;
            end else begin
              w_next = S_REQ;
            end
          end
        end
`else
        if (npc_valid) begin
          w_pc_d     = npc_in;
          w_ivalid_d = 1'b0;
          w_next     = S_REQ;
        end
`endif
      end
      default: w_next = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_BOOT;
      r_pc     <= RESET_PC[AW-1:0];
      r_instr  <= 32'h0;
      r_ivalid <= 1'b0;
`ifdef PC_FETCH_PREFETCH_EN
      r_pf_req   <= 1'b0;
      r_pf_out   <= 1'b0;
      r_pf_valid <= 1'b0;
      r_pf_data  <= 32'h0;
      r_drain    <= 1'b0;
`endif
    end else begin
      r_state  <= w_next;
      r_pc     <= w_pc_d;
      r_instr  <= w_instr_d;
      r_ivalid <= w_ivalid_d;
`ifdef PC_FETCH_PREFETCH_EN
      r_pf_req   <= w_pf_req_d;
      r_pf_out   <= w_pf_out_d;
      r_pf_valid <= w_pf_valid_d;
      r_pf_data  <= w_pf_data_d;
      r_drain    <= w_drain_d;
`endif
    end
  end

  assign pc_out      = r_pc;
  assign link_out    = w_link;
  assign imem_req    = w_req;
  assign imem_addr   = w_addr;
  assign instr_out   = r_instr;
  assign instr_valid = r_ivalid;
  assign busy        = (r_state != S_ISSUE);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit: memory timing and redirects driven
// per fetch transaction, outputs checked against a transaction-level model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc_in;
  logic        npc_valid;
  logic [31:0] pc_out;
  logic [31:0] link_out;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_pc;

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .RESET_PC(RST_PC),
    .AW      (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .npc_in     (npc_in),
    .npc_valid  (npc_valid),
    .pc_out     (pc_out),
    .link_out   (link_out),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_out  (instr_out),
    .instr_valid(instr_valid),
    .busy       (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    npc_valid   = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
  endtask

  // One fetch transaction, entered right after the edge into REQ.
  // gd: cycles gnt is held low; rd: extra WAIT cycles before rvalid.
  task automatic fetch(input int gd, input int rd,
                       input logic [31:0] word,
                       input bit rst_mid,
                       input logic [31:0] nxt);
    int hold;
    for (int k = 0; k <= gd; k++) begin
      chk("req_hi", imem_req, 1);
      chk("req_addr", imem_addr, m_pc);
      chk("req_pc", pc_out, m_pc);
      chk("req_busy", busy, 1);
      chk("req_ivld", instr_valid, 0);
      imem_gnt    = (k == gd);
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      npc_valid   = 1'($urandom_range(0, 1));
      npc_in      = $urandom;
      tick();
    end
    idle_in();
    if (rst_mid) begin
      chk("rw_req", imem_req, 0);
      rst         = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
      tick();
      rst = 1'b0;
      m_pc = RST_PC;
      chk("rw_pc", pc_out, m_pc);
      chk("rw_ivld", instr_valid, 0);
      chk("rw_req0", imem_req, 0);
      chk("rw_instr", instr_out, 0);
      imem_rvalid = 1'b1;
      tick();
      imem_rvalid = 1'b0;
      chk("rw_ivld2", instr_valid, 0);
      return;
    end
    for (int j = 0; j <= rd; j++) begin
      chk("wait_req", imem_req, 0);
      chk("wait_ivld", instr_valid, 0);
      chk("wait_busy", busy, 1);
      chk("wait_pc", pc_out, m_pc);
      imem_rvalid = (j == rd);
      imem_rdata  = (j == rd) ? word : $urandom;
      imem_gnt    = 1'($urandom_range(0, 1));
      npc_valid   = 1'($urandom_range(0, 1));
      npc_in      = $urandom;
      tick();
    end
    idle_in();
    hold = $urandom_range(0, 3);
    for (int h = 0; h <= hold; h++) begin
      chk("iss_ivld", instr_valid, 1);
      chk("iss_instr", instr_out, word);
      chk("iss_pc", pc_out, m_pc);
      chk("iss_link", link_out, m_pc + 32'd1);
      chk("iss_busy", busy, 0);
      chk("iss_req", imem_req, 0);
      imem_gnt    = 1'($urandom_range(0, 1));
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      npc_valid   = (h == hold);
      npc_in      = nxt;
      tick();
    end
    idle_in();
    m_pc = nxt;
    chk("step_ivld", instr_valid, 0);
  endtask

  initial begin
    logic [31:0] nxt;
    rst        = 1'b1;
    npc_in     = 32'h0;
    imem_rdata = 32'h0;
    idle_in();
    tick();
    imem_rvalid = 1'b1;
    npc_valid   = 1'b1;
    tick();
    chk("rst_pc", pc_out, RST_PC);
    chk("rst_ivld", instr_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_busy", busy, 1);
    rst = 1'b0;
    idle_in();
    imem_rvalid = 1'b1;
    tick();
    imem_rvalid = 1'b0;
    m_pc = RST_PC;

    fetch(0, 0, 32'h8C01_0004, 1'b0, 32'h0000_0011);
    fetch(5, 2, $urandom, 1'b0, 32'h0000_0200);
    fetch(0, 0, $urandom, 1'b0, 32'hFFFF_FFFF);
    fetch(1, 0, $urandom, 1'b0, 32'h0000_0000);
    fetch(0, 1, $urandom, 1'b1, 32'h0);
    for (int i = 0; i < 40; i++) begin
      nxt = ($urandom_range(0, 1) != 0) ? m_pc + 32'd1 : $urandom;
      fetch($urandom_range(0, 4), $urandom_range(0, 3), $urandom,
            ($urandom_range(0, 9) == 0), nxt);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the architectural program counter and drives it to the next-PC logic.
- Fetches one instruction word per PC from instruction memory over a req/gnt/rvalid handshake, then holds it for decode.
- Loads the next-PC value returned by the next-PC logic (sequential, branch, jump or jump-register) once execute completes.
- Sits between the next-PC logic and the decode stage of the multicycle core. PC is word-addressed: sequential successor is pc+1.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- AW, 32, PC / instruction address width.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous active-high reset.
- npc_in  input  AW  next PC from the next-PC logic.
- npc_valid  input  1  execute done; npc_in is valid this cycle.
- pc_out  output  AW  current PC, feeds the next-PC logic pc input.
- link_out  output  AW  pc_out+1, the return address written by jal.
- imem_req  output  1  fetch request.
- imem_addr  output  AW  fetch word address.
- imem_gnt  input  1  memory accepted the request.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  instruction word.
- instr_out  output  32  held instruction for decode.
- instr_valid  output  1  instr_out is valid.
- busy  output  1  high in every state except ISSUE.

Behaviour:
- Reset values (synchronous, rst=1 at posedge): pc_out=RESET_PC, instr_out=0, instr_valid=0, imem_req=0, state=BOOT. Any in-flight memory response is discarded.
- States: BOOT, REQ, WAIT, ISSUE.
- BOOT: one cycle after reset deasserts, then go to REQ. imem_rvalid is ignored in this state.
- REQ: imem_req=1, imem_addr=pc_out. Stay while imem_gnt=0. On imem_gnt=1, go to WAIT. imem_req drops the cycle after gnt.
- WAIT: imem_req=0. On imem_rvalid=1, instr_out<=imem_rdata, instr_valid<=1, go to ISSUE. Memory never asserts rvalid in the same cycle as gnt.
- ISSUE: instr_out and pc_out are stable. On npc_valid=1: pc_out<=npc_in, instr_valid<=0, go to REQ.
- Latency: minimum PC-to-instr_valid is 3 cycles (REQ, WAIT, ISSUE).
- npc_valid in BOOT, REQ or WAIT is ignored. The PC does not change outside ISSUE.
- imem_rvalid outside WAIT is ignored.
- imem_gnt outside REQ is ignored.
- Arithmetic: link_out = pc_out+1, mod 2^AW. pc_out=all-ones gives link_out=0. npc_in is loaded unchanged, with no alignment or range check.
- rst has priority over every other input in every state, including mid-handshake.

Optional Feature:
- Macro: PC_FETCH_PREFETCH_EN.
- Defined: adds a one-entry sequential prefetch buffer. On entering ISSUE, the unit issues a req/gnt/rvalid fetch of pc_out+1 and stores the result with a pf_valid flag.
  - On npc_valid with npc_in==pc_out+1 and pf_valid=1: next cycle goes directly to ISSUE with the buffered word. The REQ/WAIT cycles are skipped.
  - On npc_valid with npc_in==pc_out+1 while the prefetch is still outstanding: go to WAIT and use that response.
  - On npc_valid with any other npc_in: set pf_valid=0. Any outstanding prefetch response is received and discarded (drain in WAIT), then go to REQ for npc_in.
  - Reset clears pf_valid.
- Undefined: no prefetch. imem_req is asserted only in REQ.

Test Plan:
- Reset with RESET_PC=0x10, memory gnt same cycle, rvalid next cycle, rdata=0x8C01_0004 -> imem_addr=0x10 in REQ; instr_valid=1 and instr_out=0x8C01_0004 three cycles after BOOT; link_out=0x11.
- Sequential step: in ISSUE, npc_valid=1, npc_in=0x11 -> pc_out=0x11 next cycle, instr_valid=0, imem_req=1 with imem_addr=0x11.
- Branch/jump redirect: npc_in=0x0000_0200 while pc_out=0x11 -> next fetch address 0x200. npc_valid pulses during REQ and WAIT leave pc_out=0x11 unchanged.
- Memory stall: gnt held low 5 cycles, then rvalid 3 cycles after gnt -> imem_req high for exactly the 6 REQ cycles; busy=1 throughout; instr_valid rises only after rvalid.
- Reset mid-WAIT followed by a stray rvalid in BOOT -> instr_valid stays 0; pc_out=RESET_PC; a fresh REQ is issued.
- With PC_FETCH_PREFETCH_EN defined: sequential npc_in=pc+1 after the prefetch completes -> instr_valid in 1 cycle. Taken jump -> prefetched word is discarded and the instruction at the jump target is fetched and issued.
